// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low glyph patterns, capture FSM states
// and the pattern-to-nibble decoder used by both display and capture blocks.
package sseg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_HOLD
   } sseg_state_t;

   typedef struct packed {
      logic [3:0] nibble;
      logic       blank;
      logic       err;
   } seg_dec_t;

   // Unknown patterns decode to nibble 0 with err set, so a bad digit never aliases a real one.
   function automatic seg_dec_t seg_decode(input logic [6:0] seg);
      seg_dec_t d;
      d.nibble = 4'h0;
      d.blank  = 1'b0;
      d.err    = 1'b0;
      case (seg)
         SEG_0:     d.nibble = 4'h0;
         SEG_1:     d.nibble = 4'h1;
         SEG_2:     d.nibble = 4'h2;
         SEG_3:     d.nibble = 4'h3;
         SEG_4:     d.nibble = 4'h4;
         SEG_5:     d.nibble = 4'h5;
         SEG_6:     d.nibble = 4'h6;
         SEG_7:     d.nibble = 4'h7;
         SEG_8:     d.nibble = 4'h8;
         SEG_9:     d.nibble = 4'h9;
         SEG_A:     d.nibble = 4'hA;
         SEG_B:     d.nibble = 4'hB;
         SEG_C:     d.nibble = 4'hC;
         SEG_D:     d.nibble = 4'hD;
         SEG_E:     d.nibble = 4'hE;
         SEG_F:     d.nibble = 4'hF;
         SEG_BLANK: d.blank  = 1'b1;
         default:   d.err    = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational decode of one active-low segment byte {dp,g..a} into nibble and flags.
module sseg_glyph_decode
   import sseg_pkg::*;
(
   input  logic [7:0] sig,
   output logic [3:0] nibble,
   output logic       dp,
   output logic       blank,
   output logic       err
);

   seg_dec_t dec;

   assign dec    = seg_decode(sig[6:0]);
   assign nibble = dec.nibble;
   assign blank  = dec.blank;
   assign err    = dec.err;
   assign dp     = ~sig[7];

endmodule

// File: rtl/sseg_capture.sv
// Passive monitor for a multiplexed active-low seven-segment bus: debounces each
// anode/pattern pair, decodes it and publishes a 4-digit word once all digits are seen.
module sseg_capture
   import sseg_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  sseg_an,
   input  logic [7:0]  sseg_sig,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic [3:0]  blank,
   output logic [3:0]  err,
   output logic        frame_valid,
   output logic        active
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0][3:0] an_sync;
   logic [SYNC_STAGES-1:0][7:0] sig_sync;
   logic [3:0]  an_s;
   logic [7:0]  sig_s;
   logic [11:0] cur_pair;
   logic        an_valid;

   sseg_state_t state;
   logic [11:0] pair_q;
   logic [SW-1:0] settle_cnt;
   logic [TW-1:0] to_cnt;
   logic [3:0]  seen;
   logic [15:0] sh_value;
   logic [3:0]  sh_dp, sh_blank, sh_err;

   logic [3:0]  dec_nibble;
   logic        dec_dp, dec_blank, dec_err;
   logic [1:0]  cap_idx;
   logic [15:0] sh_value_n;
   logic [3:0]  sh_dp_n, sh_blank_n, sh_err_n, seen_upd;

   function automatic logic [1:0] an_index(input logic [3:0] an);
      case (an)
         4'b1101: an_index = 2'd1;
         4'b1011: an_index = 2'd2;
         4'b0111: an_index = 2'd3;
         default: an_index = 2'd0;
      endcase
   endfunction

   // Reset drives the synchroniser to all-zero anodes, which reads as an invalid bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_sync  <= '0;
         sig_sync <= '0;
      end else begin
         an_sync  <= {an_sync[SYNC_STAGES-2:0], sseg_an};
         sig_sync <= {sig_sync[SYNC_STAGES-2:0], sseg_sig};
      end
   end

   assign an_s     = an_sync[SYNC_STAGES-1];
   assign sig_s    = sig_sync[SYNC_STAGES-1];
   assign cur_pair = {an_s, sig_s};
   assign an_valid = ($countones(~an_s) == 1);

   sseg_glyph_decode u_decode (
      .sig    (pair_q[7:0]),
      .nibble (dec_nibble),
      .dp     (dec_dp),
      .blank  (dec_blank),
      .err    (dec_err)
   );

   assign cap_idx  = an_index(pair_q[11:8]);
   assign seen_upd = seen | (4'b0001 << cap_idx);

   // Next shadow contents, so a completing capture can publish its own digit in the same edge.
   always_comb begin
      sh_value_n = sh_value;
      sh_dp_n    = sh_dp;
      sh_blank_n = sh_blank;
      sh_err_n   = sh_err;
      if (state == ST_CAPTURE) begin
         sh_value_n[4*cap_idx +: 4] = dec_nibble;
         sh_dp_n[cap_idx]           = dec_dp;
         sh_blank_n[cap_idx]        = dec_blank;
         sh_err_n[cap_idx]          = dec_err;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         pair_q      <= '0;
         settle_cnt  <= '0;
         to_cnt      <= '0;
         seen        <= '0;
         sh_value    <= '0;
         sh_dp       <= '0;
         sh_blank    <= '0;
         sh_err      <= '0;
         value       <= '0;
         dp          <= '0;
         blank       <= '0;
         err         <= '0;
         frame_valid <= 1'b0;
         active      <= 1'b0;
      end else begin
         frame_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (an_valid) begin
                  state      <= ST_SETTLE;
                  pair_q     <= cur_pair;
                  settle_cnt <= SW'(1);
               end
            end
            ST_SETTLE: begin
               if (!an_valid) begin
                  state <= ST_IDLE;
               end else if (cur_pair != pair_q) begin
                  pair_q     <= cur_pair;
                  settle_cnt <= SW'(1);
               end else if (settle_cnt == SETTLE_MAX) begin
                  state <= ST_CAPTURE;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            ST_CAPTURE: state <= ST_HOLD;
            ST_HOLD: begin
               if (!an_valid) begin
                  state <= ST_IDLE;
               end else if (cur_pair != pair_q) begin
                  state      <= ST_SETTLE;
                  pair_q     <= cur_pair;
                  settle_cnt <= SW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase

         // A capture always wins over timeout saturation in the same cycle.
         if (state == ST_CAPTURE) begin
            sh_value <= sh_value_n;
            sh_dp    <= sh_dp_n;
            sh_blank <= sh_blank_n;
            sh_err   <= sh_err_n;
            to_cnt   <= '0;
            active   <= 1'b1;
            if (seen_upd == 4'hF) begin
               value       <= sh_value_n;
               dp          <= sh_dp_n;
               blank       <= sh_blank_n;
               err         <= sh_err_n;
               frame_valid <= 1'b1;
               seen        <= '0;
            end else begin
               seen <= seen_upd;
            end
         end else begin
            if (to_cnt == TO_MAX) seen <= '0;
            else                  to_cnt <= to_cnt + TW'(1);
            if (to_cnt >= TO_MAX - TW'(1)) active <= 1'b0;
         end
      end
   end

endmodule
